// File: rtl/edge_pkg.sv
// Shared types and mode encodings for the edge stream filter.
package edge_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_PASS = 2'd0;
  localparam mode_t MODE_HALF = 2'd1;
  localparam mode_t MODE_GRAD = 2'd2;
  localparam mode_t MODE_BIN  = 2'd3;

endpackage

// File: rtl/pixel_delay_line.sv
// Fixed-depth shift register with async active-low reset. The penultimate
// stage is tapped so consumers can register a result aligned with data_o.
module pixel_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] tap_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign data_o = sr_q[DEPTH-1];

  // With a single stage the "one before the output" value is the input itself.
  generate
    if (DEPTH > 1) begin : g_tap
      assign tap_o = sr_q[DEPTH-2];
    end else begin : g_tap_in
      assign tap_o = data_i;
    end
  endgenerate

endmodule

// File: rtl/edge_stream_filter.sv
// One-pixel-per-clock filter stage: pass / halve / horizontal gradient /
// binary edge, plus a per-frame edge-pixel counter. Free-running stream, no backpressure.
module edge_stream_filter
  import edge_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 8,
  parameter int CNT_W   = 20
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic [WIDTH-1:0] PixelIn,
  input  logic             FrameIn,
  input  logic             LineIn,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] Threshold,
  output logic [WIDTH-1:0] PixelOut,
  output logic             FrameOut,
  output logic             LineOut,
  output logic [CNT_W-1:0] EdgeCount,
  output logic             CountValid
);

  localparam int DEPTH = LATENCY - 3;
  localparam int DW    = WIDTH + 3;

  mode_t            mode_q, eff_mode;
  logic [WIDTH-1:0] thr_q, eff_thr;

  // a1 holds the right neighbour, a2 the centre, a3 the left neighbour.
  logic [WIDTH-1:0] a1_px_q, a2_px_q, a3_px_q;
  logic             a1_frame_q, a2_frame_q, a1_line_q, a2_line_q;
  mode_t            a1_mode_q, a2_mode_q;
  logic [WIDTH-1:0] a1_thr_q, a2_thr_q;

  logic [WIDTH-1:0] left, right, grad;
  logic [WIDTH-1:0] s3_px_d, s3_px_q;
  logic             s3_edge_d, s3_edge_q, s3_frame_q, s3_line_q;

  logic [DW-1:0]    tail, tap;
  logic             tap_frame, tap_edge;

  logic [CNT_W-1:0] acc_d, acc_q, ec_d, ec_q;
  logic             cv_d, cv_q, first_d, first_q;
  logic             unused_bits;

  // A pixel carrying FrameIn uses the Mode/Threshold of its own cycle.
  assign eff_mode = FrameIn ? Mode : mode_q;
  assign eff_thr  = FrameIn ? Threshold : thr_q;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      mode_q     <= MODE_PASS;
      thr_q      <= '0;
      a1_px_q    <= '0;
      a2_px_q    <= '0;
      a3_px_q    <= '0;
      a1_frame_q <= 1'b0;
      a2_frame_q <= 1'b0;
      a1_line_q  <= 1'b0;
      a2_line_q  <= 1'b0;
      a1_mode_q  <= MODE_PASS;
      a2_mode_q  <= MODE_PASS;
      a1_thr_q   <= '0;
      a2_thr_q   <= '0;
      s3_px_q    <= '0;
      s3_edge_q  <= 1'b0;
      s3_frame_q <= 1'b0;
      s3_line_q  <= 1'b0;
    end else begin
      mode_q     <= eff_mode;
      thr_q      <= eff_thr;
      a1_px_q    <= PixelIn;
      a1_frame_q <= FrameIn;
      a1_line_q  <= LineIn;
      a1_mode_q  <= eff_mode;
      a1_thr_q   <= eff_thr;
      a2_px_q    <= a1_px_q;
      a2_frame_q <= a1_frame_q;
      a2_line_q  <= a1_line_q;
      a2_mode_q  <= a1_mode_q;
      a2_thr_q   <= a1_thr_q;
      a3_px_q    <= a2_px_q;
      s3_px_q    <= s3_px_d;
      s3_edge_q  <= s3_edge_d;
      s3_frame_q <= a2_frame_q;
      s3_line_q  <= a2_line_q;
    end
  end

  // Line boundaries replicate the centre pixel into the missing neighbour.
  always_comb begin
    left      = a2_line_q ? a2_px_q : a3_px_q;
    right     = a1_line_q ? a2_px_q : a1_px_q;
    grad      = (right >= left) ? (right - left) : (left - right);
    s3_edge_d = (grad >= a2_thr_q);
    s3_px_d   = a2_px_q;
    case (a2_mode_q)
      MODE_PASS: s3_px_d = a2_px_q;
      MODE_HALF: s3_px_d = a2_px_q >> 1;
      MODE_GRAD: s3_px_d = grad;
      MODE_BIN:  s3_px_d = s3_edge_d ? '1 : '0;
      default:   s3_px_d = a2_px_q;
    endcase
  end

  pixel_delay_line #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_tail (
    .clk_i  (Clk),
    .rst_ni (nReset),
    .data_i ({s3_px_q, s3_frame_q, s3_line_q, s3_edge_q}),
    .data_o (tail),
    .tap_o  (tap)
  );

  assign PixelOut  = tail[DW-1:3];
  assign FrameOut  = tail[2];
  assign LineOut   = tail[1];
  assign tap_frame = tap[2];
  assign tap_edge  = tap[0];
  assign unused_bits = ^{tail[0], tap[DW-1:3], tap[1]};

  // Counter runs one stage ahead so its registers update with FrameOut.
  always_comb begin
    acc_d   = acc_q;
    ec_d    = ec_q;
    cv_d    = 1'b0;
    first_d = first_q;
    if (tap_frame) begin
      acc_d   = CNT_W'(tap_edge);
      first_d = 1'b0;
      if (!first_q) begin
        ec_d = acc_q;
        cv_d = 1'b1;
      end
    end else if (tap_edge && (acc_q != '1)) begin
      acc_d = acc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      acc_q   <= '0;
      ec_q    <= '0;
      cv_q    <= 1'b0;
      first_q <= 1'b1;
    end else begin
      acc_q   <= acc_d;
      ec_q    <= ec_d;
      cv_q    <= cv_d;
      first_q <= first_d;
    end
  end

  assign EdgeCount  = ec_q;
  assign CountValid = cv_q;

endmodule

// File: tb/tb_edge_stream_filter.sv
// Directed vector bench for edge_stream_filter: main instance with default
// counter width plus a narrow-counter instance for saturation.
module tb_edge_stream_filter;

  localparam int LAT = 8;

  logic       Clk = 1'b0;
  logic       nReset = 1'b0;
  logic [7:0] PixelIn = '0;
  logic       FrameIn = 1'b0;
  logic       LineIn = 1'b0;
  logic [1:0] Mode = '0;
  logic [7:0] Threshold = '0;

  logic [7:0]  PixelOut, PixelOut2;
  logic        FrameOut, FrameOut2, LineOut, LineOut2;
  logic [19:0] EdgeCount;
  logic [1:0]  EdgeCount2;
  logic        CountValid, CountValid2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        f, l;
    logic [1:0]  m;
    logic [7:0]  t, p;
    bit          chk;
    logic [7:0]  ep;
    logic        ef, el, cv;
    logic [19:0] ec;
    bit          chk2;
    logic [1:0]  ec2;
    logic        cv2;
  } vec_t;

  vec_t vecs[$];

  edge_stream_filter #(.WIDTH(8), .LATENCY(LAT), .CNT_W(20)) dut (
    .Clk(Clk), .nReset(nReset), .PixelIn(PixelIn), .FrameIn(FrameIn),
    .LineIn(LineIn), .Mode(Mode), .Threshold(Threshold), .PixelOut(PixelOut),
    .FrameOut(FrameOut), .LineOut(LineOut), .EdgeCount(EdgeCount),
    .CountValid(CountValid)
  );

  edge_stream_filter #(.WIDTH(8), .LATENCY(LAT), .CNT_W(2)) dut_sat (
    .Clk(Clk), .nReset(nReset), .PixelIn(PixelIn), .FrameIn(FrameIn),
    .LineIn(LineIn), .Mode(Mode), .Threshold(Threshold), .PixelOut(PixelOut2),
    .FrameOut(FrameOut2), .LineOut(LineOut2), .EdgeCount(EdgeCount2),
    .CountValid(CountValid2)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic l, input logic [1:0] m,
                       input logic [7:0] t, input logic [7:0] p);
    FrameIn = f; LineIn = l; Mode = m; Threshold = t; PixelIn = p;
  endtask

  task automatic tick(input logic f, input logic l, input logic [1:0] m,
                      input logic [7:0] t, input logic [7:0] p);
    @(negedge Clk);
    drive(f, l, m, t, p);
  endtask

  task automatic add(input bit f, input bit l, input bit [1:0] m, input bit [7:0] t,
                     input bit [7:0] p, input bit chk, input bit [7:0] ep, input bit ef,
                     input bit el, input bit cv, input int ec, input bit chk2,
                     input bit [1:0] ec2, input bit cv2);
    vec_t v;
    v.f = f; v.l = l; v.m = m; v.t = t; v.p = p;
    v.chk = chk; v.ep = ep; v.ef = ef; v.el = el; v.cv = cv; v.ec = 20'(ec);
    v.chk2 = chk2; v.ec2 = ec2; v.cv2 = cv2;
    vecs.push_back(v);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pix"}, 32'(PixelOut), 32'h0);
    check({tag, "_frame"}, 32'(FrameOut), 32'h0);
    check({tag, "_line"}, 32'(LineOut), 32'h0);
    check({tag, "_cv"}, 32'(CountValid), 32'h0);
    check({tag, "_ec"}, 32'(EdgeCount), 32'h0);
    check({tag, "_cv2"}, 32'(CountValid2), 32'h0);
    check({tag, "_ec2"}, 32'(EdgeCount2), 32'h0);
  endtask

  // Vector j is driven at negedge j; its result is visible at negedge j+LAT.
  task automatic play(input string set_name);
    vec_t v;
    int n;
    n = vecs.size();
    for (int j = 0; j < n + LAT; j++) begin
      @(negedge Clk);
      if (j >= LAT) begin
        v = vecs[j-LAT];
        if (v.chk) begin
          check($sformatf("%s_v%0d_pix", set_name, j-LAT), 32'(PixelOut), 32'(v.ep));
          check($sformatf("%s_v%0d_frame", set_name, j-LAT), 32'(FrameOut), 32'(v.ef));
          check($sformatf("%s_v%0d_line", set_name, j-LAT), 32'(LineOut), 32'(v.el));
          check($sformatf("%s_v%0d_cv", set_name, j-LAT), 32'(CountValid), 32'(v.cv));
          check($sformatf("%s_v%0d_ec", set_name, j-LAT), 32'(EdgeCount), 32'(v.ec));
        end
        if (v.chk2) begin
          check($sformatf("%s_v%0d_ec2", set_name, j-LAT), 32'(EdgeCount2), 32'(v.ec2));
          check($sformatf("%s_v%0d_cv2", set_name, j-LAT), 32'(CountValid2), 32'(v.cv2));
        end
      end
      if (j < n) drive(vecs[j].f, vecs[j].l, vecs[j].m, vecs[j].t, vecs[j].p);
      else       drive(1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
    end
    vecs.delete();
  endtask

  initial begin
    // Reset held with random inputs: all outputs must stay 0.
    for (int i = 0; i < 4; i++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      check_zero($sformatf("rst%0d", i));
    end
    tick(1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
    nReset = 1'b1;
    repeat (3) tick(1'b0, 1'b0, 2'd0, 8'h00, 8'h00);

    // f l m thr px | chk exp f l cv ec | chk2 ec2 cv2
    add(1,1,0,8'hFF,8'h10, 1,8'h10,1,1,0,0, 0,0,0); // first frame: pass, no CountValid
    add(0,0,2,8'hFF,8'h22, 1,8'h22,0,0,0,0, 0,0,0); // mode change mid-frame ignored
    add(0,0,2,8'hFF,8'h05, 1,8'h05,0,0,0,0, 0,0,0);
    add(1,1,1,8'hFE,8'hFF, 1,8'h7F,1,1,1,0, 0,0,0); // halve
    add(0,0,1,8'hFF,8'h01, 1,8'h00,0,0,0,0, 0,0,0);
    add(0,1,1,8'hFF,8'h80, 1,8'h40,0,1,0,0, 0,0,0);
    add(1,1,2,8'hFF,8'h0A, 1,8'h0A,1,1,1,2, 0,0,0); // gradient; prev frame had G==thr twice
    add(0,0,2,8'hFF,8'h14, 1,8'h28,0,0,0,2, 0,0,0);
    add(0,0,2,8'hFF,8'h32, 1,8'h1E,0,0,0,2, 0,0,0);
    add(0,0,2,8'hFF,8'h32, 1,8'h00,0,0,0,2, 0,0,0);
    add(1,1,3,8'h1E,8'h0A, 1,8'h00,1,1,1,0, 0,0,0); // binary, thr 30
    add(0,0,3,8'h1E,8'h14, 1,8'hFF,0,0,0,0, 0,0,0);
    add(0,0,3,8'h1E,8'h32, 1,8'hFF,0,0,0,0, 0,0,0);
    add(0,0,3,8'h1E,8'h32, 1,8'h00,0,0,0,0, 0,0,0);
    add(1,1,0,8'hFF,8'h33, 1,8'h33,1,1,1,2, 0,0,0); // binary frame counted 2 edges
    add(0,0,0,8'hFF,8'h44, 1,8'h44,0,0,0,2, 0,0,0); // CountValid only one cycle
    add(0,1,2,8'hFF,8'h55, 1,8'h55,0,1,0,2, 0,0,0); // 0->2 mid-frame stays pass
    add(0,0,2,8'hFF,8'h66, 1,8'h66,0,0,0,2, 0,0,0);
    add(1,1,2,8'hFF,8'h10, 1,8'h20,1,1,1,0, 0,0,0); // gradient from next frame start
    add(0,0,2,8'hFF,8'h30, 1,8'h20,0,0,0,0, 0,0,0);
    add(0,1,2,8'hFF,8'h00, 1,8'h00,0,1,0,0, 0,0,0);
    add(1,1,0,8'h00,8'h07, 1,8'h07,1,1,1,0, 0,0,0); // thr 0: every pixel of this frame is an edge
    play("main");

    // Frame of ten pixels; its FrameOut reports the 9-pixel thr-0 frame.
    for (int k = 0; k < 10; k++) begin
      tick(k == 0, k == 0, 2'd0, 8'hFF, 8'(8'hA0 + k));
      if (k == 8) begin
        check("pre_rst_frame", 32'(FrameOut), 32'h1);
        check("pre_rst_ec", 32'(EdgeCount), 32'd9);
        check("pre_rst_cv", 32'(CountValid), 32'h1);
        check("pre_rst_ec2_sat", 32'(EdgeCount2), 32'd3);
        check("pre_rst_cv2", 32'(CountValid2), 32'h1);
      end
    end
    check("pre_rst_pix", 32'(PixelOut), 32'hA1);
    #2 nReset = 1'b0;
    #1 check_zero("async_rst");
    repeat (2) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    check_zero("rst_hold");
    tick(1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
    nReset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
      check_zero($sformatf("post_rst%0d", i));
    end

    add(1,1,0,8'h00,8'h5A, 1,8'h5A,1,1,0,0, 1,0,0); // first frame after reset: no CountValid
    add(0,0,0,8'hFF,8'h01, 1,8'h01,0,0,0,0, 1,0,0);
    add(0,0,0,8'hFF,8'h02, 1,8'h02,0,0,0,0, 1,0,0);
    add(0,0,0,8'hFF,8'h03, 1,8'h03,0,0,0,0, 1,0,0);
    add(0,0,0,8'hFF,8'h04, 1,8'h04,0,0,0,0, 1,0,0);
    add(1,1,0,8'hFF,8'h77, 1,8'h77,1,1,1,5, 1,3,1); // 5 edges; 2-bit counter saturates at 3
    add(0,0,0,8'hFF,8'h00, 1,8'h00,0,0,0,5, 1,3,0);
    play("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/edge_stream_filter.md
Name: edge_stream_filter

Overview:
Streaming pixel-pipeline stage with selectable processing mode, one pixel per clock. It sits between the camera/pixel source and the Hough accumulator. It generalises the fixed 8-cycle halving delay to configurable pixel width and latency. It adds a horizontal gradient edge detector, a binary threshold mode and a per-frame edge-pixel counter.

Parameters:
WIDTH, 8, pixel bit width (>=2)
LATENCY, 8, input-to-output latency in cycles for pixel and sync (>=4)
CNT_W, 20, EdgeCount width

Ports:
Clk  in  1  clock, all logic on rising edge
nReset  in  1  asynchronous active-low reset
PixelIn  in  WIDTH  pixel, valid every cycle
FrameIn  in  1  1-cycle pulse with first pixel of a frame (LineIn also high)
LineIn  in  1  1-cycle pulse with first pixel of each line
Mode  in  2  0 pass, 1 halve, 2 gradient, 3 binary edge
Threshold  in  WIDTH  edge threshold
PixelOut  out  WIDTH  processed pixel
FrameOut  out  1  FrameIn delayed by LATENCY
LineOut  out  1  LineIn delayed by LATENCY
EdgeCount  out  CNT_W  edge-pixel total of the previous frame
CountValid  out  1  1-cycle pulse when EdgeCount updates

Behaviour:
- Reset (async, any time, including mid-frame): every pipeline register, PixelOut, FrameOut, LineOut, EdgeCount and CountValid go to 0. The mode shadow and threshold shadow go to 0. The first_frame flag is set. No output activity during reset.
- Latency: a pixel presented at cycle t appears processed on PixelOut at t+LATENCY. FrameOut and LineOut are exactly aligned with it.
- Mode and Threshold are sampled only on cycles where FrameIn=1. The sampled values apply to that pixel and every later pixel until the next FrameIn. Changes mid-frame are ignored. Before the first FrameIn after reset, mode 0 (pass) applies.
- Window: centre pixel C(x), left L=C(x-1), right R=C(x+1).
  - If C is the first pixel of a line (its LineIn=1), L=C.
  - If the pixel after C has LineIn=1, R=C.
  - A one-pixel line gives L=R=C.
- Gradient G = |R - L|, WIDTH bits, unsigned, never overflows.
- Output per mode: 0 -> C; 1 -> C>>1 (logical shift); 2 -> G; 3 -> all-ones if G >= Threshold else 0.
- The last pixel of a frame is resolved by the next LineIn. If input stalls mid-line, the output for the final pixel waits for the following pixel.
- Edge counter:
  - Counts pixels with G >= Threshold in every mode.
  - The accumulator saturates at 2^CNT_W-1.
  - On the cycle FrameOut=1: EdgeCount <= accumulated total of the preceding frame and CountValid=1. The accumulator then restarts, with the current pixel counted as the first pixel.
  - On the first FrameOut after reset, EdgeCount is not updated and CountValid stays 0. Pre-frame pixels are discarded and first_frame is cleared.
  - EdgeCount holds its value between updates.
- Pipeline structure: 3 window/compute stages, then a LATENCY-3 deep delay line carrying {pixel, frame, line, edge flag}.

Decomposition:
- Package edge_pkg: mode constants MODE_PASS=0, MODE_HALF=1, MODE_GRAD=2, MODE_BIN=3, and the 2-bit mode typedef.
- Sub-module pixel_delay_line: parameters WIDTH and DEPTH, async active-low reset, shift register. Instantiated once for the tail delay, with the sync bits and edge flag concatenated into the data.

Test Plan:
1. Reset: hold nReset=0 and drive random inputs -> all outputs 0. Release, then FrameIn+LineIn with pixel 0x10 and Mode=0 -> at +8 cycles PixelOut=0x10 with FrameOut=LineOut=1 in the same cycle; CountValid stays 0.
2. Mode=1 at FrameIn, pixel 0xFF -> PixelOut=0x7F; pixel 0x01 -> 0x00.
3. Mode=2 at FrameIn, line 10,20,50,50 then next LineIn -> PixelOut 10,40,30,0.
4. Mode=3, Threshold=30, same line, then another FrameIn -> PixelOut 0x00,0xFF,0xFF,0x00. At the next FrameOut, EdgeCount=2 and CountValid=1 for exactly one cycle.
5. Mode changed 0->2 mid-frame -> the rest of the frame stays passthrough; gradient starts at the next FrameIn pixel.
6. nReset pulsed mid-line, then a new frame -> no stale pixels or syncs appear; first FrameOut gives no CountValid. CNT_W=2 with 5 edges in a frame -> EdgeCount=3 (saturated).
